// File: rtl/tt_dsrt_pkg.sv
// -----------------------------------------------------------------------------
// tt_dsrt_pkg
// Shared definitions for the tt_um_dsrt_logic_array tile.
//   dsrt_mode_e : per-array processing mode, decoded from uio_in[1:0]
//   UIO_OE_CNT  : bidirectional output enables when the edge counter is built
//   CNT_W       : width of the channel-0 rising-edge counter
// -----------------------------------------------------------------------------
package tt_dsrt_pkg;

  typedef enum logic [1:0] {
    MODE_INVERT = 2'd0,
    MODE_PASS   = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_PULSE  = 2'd3
  } dsrt_mode_e;

  // Counter occupies uio[7:3]; uio[2:0] stay inputs for mode/hold.
  localparam logic [7:0] UIO_OE_CNT = 8'hF8;

  localparam int unsigned CNT_W = 5;

endpackage

// File: rtl/tt_dsrt_sync.sv
// -----------------------------------------------------------------------------
// tt_dsrt_sync
// Multi-bit flop-chain synchroniser with asynchronous active-low clear. Each
// bit is synchronised independently; there is no bus coherency guarantee.
//   clk_i  : sampling clock
//   rst_ni : asynchronous active-low clear of every stage
//   d_i    : asynchronous input bits
//   q_o    : synchronised bits, Depth cycles after capture
// Parameters: Width (bits), Depth (stages, >= 2).
// -----------------------------------------------------------------------------
module tt_dsrt_sync #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // stage_q[0] is the first (metastability-exposed) stage.
  logic [Depth-1:0][Width-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[Depth-2:0], d_i};
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/tt_um_dsrt_logic_array.sv
// -----------------------------------------------------------------------------
// tt_um_dsrt_logic_array
// Multi-channel registered logic array for the TinyTapeout harness. Each of the
// WIDTH channels on ui_in is synchronised, then inverted, passed, toggled on
// rising edge or pulsed on rising edge according to a shared run-time mode,
// and registered onto uo_out. A hold control freezes the output register.
//
// Ports:
//   clk     : single clock, all state on the rising edge
//   rst_n   : asynchronous active-low reset, clears every flop
//   ui_in   : channel inputs, bits [WIDTH-1:0] used
//   uo_out  : registered channel outputs, [7:WIDTH] tied 0
//   uio_in  : [1:0] mode (dsrt_mode_e), [2] hold, [7:3] unused
//   uio_out : [7:3] channel-0 rising-edge count when built, else 0
//   uio_oe  : constant, 8'hF8 with the counter, 8'h00 without
//   ena     : ignored
//
// Parameters: WIDTH (1..8 active channels), SYNC_STAGES (>= 2).
//
// Build option: define DSRT_EDGE_CNT_EN to build the 5-bit channel-0
// rising-edge counter driven onto uio_out[7:3].
// -----------------------------------------------------------------------------
module tt_um_dsrt_logic_array
  import tt_dsrt_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  // ---------------------------------------------------------------------------
  // Synchronisers. Data and control share the same depth so that a data change
  // and a mode change captured on the same edge are processed together.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data_s;
  logic [2:0]       ctl_s;

  tt_dsrt_sync #(
    .Width (WIDTH),
    .Depth (SYNC_STAGES)
  ) u_sync_data (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (ui_in[WIDTH-1:0]),
    .q_o    (data_s)
  );

  tt_dsrt_sync #(
    .Width (3),
    .Depth (SYNC_STAGES)
  ) u_sync_ctl (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (uio_in[2:0]),
    .q_o    (ctl_s)
  );

  dsrt_mode_e mode;
  logic       hold;

  assign mode = dsrt_mode_e'(ctl_s[1:0]);
  assign hold = ctl_s[2];

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] p_q;     // previous synced data, for edge detection
  logic [WIDTH-1:0] t_q, t_d; // per-channel toggle state
  logic [WIDTH-1:0] o_q, o_d; // output register
  logic [WIDTH-1:0] rise;

  // p resets to 0, so an input held high through reset yields one rise.
  assign rise = data_s & ~p_q;

  always_comb begin
    // Toggle state advances in every mode so TOGGLE resumes coherently.
    t_d = t_q ^ rise;
    o_d = o_q;
    if (!hold) begin
      unique case (mode)
        MODE_INVERT: o_d = ~data_s;
        MODE_PASS:   o_d = data_s;
        MODE_TOGGLE: o_d = t_d;
        MODE_PULSE:  o_d = rise;
        default:     o_d = o_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      t_q <= '0;
      o_q <= '0;
    end else begin
      p_q <= data_s;
      t_q <= t_d;
      o_q <= o_d;
    end
  end

  always_comb begin
    uo_out            = '0;
    uo_out[WIDTH-1:0] = o_q;
  end

  // ---------------------------------------------------------------------------
  // Optional channel-0 rising-edge counter; independent of mode and hold.
  // ---------------------------------------------------------------------------
`ifdef DSRT_EDGE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(rise[0]);
    end
  end

  assign uio_out = {cnt_q, 3'b000};
  assign uio_oe  = UIO_OE_CNT;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

  // Harness inputs that carry no function in this tile.
  logic unused_inputs;
  assign unused_inputs = ^{ena, ui_in, uio_in[7:3]};

endmodule

// File: doc/tt_um_dsrt_logic_array.md
# tt_um_dsrt_logic_array

- Parametrised successor to the single-bit inverter tile: a multi-channel registered logic array for the TinyTapeout harness.
- Up to 8 input channels on `ui_in` are synchronised, then each is processed in one of four run-time modes (invert, pass, toggle-on-edge, pulse-on-edge) and registered to `uo_out`.
- Mode and hold controls arrive on `uio_in[2:0]`.
- An optional rising-edge counter on channel 0 drives `uio[7:3]`.

## Interface
- `WIDTH`, default 8: active channels, 1..8; `uo_out[7:WIDTH]` tied 0.
- `SYNC_STAGES`, default 2: synchroniser depth, ≥2.
- `clk` input 1: the single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ui_in` input 8: channel inputs; bits `[WIDTH-1:0]` used.
- `uo_out` output 8: registered channel outputs.
- `uio_in` input 8: `[1:0]` mode, `[2]` hold; `[7:3]` unused.
- `uio_out` output 8: `[7:3]` edge count (macro on), else 0; `[2:0]` always 0.
- `uio_oe` output 8: `8'hF8` with the macro, `8'h00` without; constant.
- `ena` input 1: ignored.

## Operation
- **Synchronisation**
  - `ui_in[WIDTH-1:0]` and `uio_in[2:0]` each pass through a `SYNC_STAGES` flop chain.
  - Synced data is `q`, synced mode is `m`, synced hold is `h`.
- **Edge detect**
  - Register `p <= q`.
  - `rise = q & ~p`, per channel.
- **Toggle state**
  - Register `t ^= rise` every cycle, in all modes, so `t` stays coherent across mode changes.
- **Output register `o`**, updated when `h == 0`:
  - `m=0` INVERT: `o <= ~q`.
  - `m=1` PASS: `o <= q`.
  - `m=2` TOGGLE: `o <= t ^ rise`, the next toggle value.
  - `m=3` PULSE: `o <= rise`.
- **Hold**: `h == 1` freezes `o`. Sync, `p`, `t` and the counter keep running.
- **Mode change**: takes effect on the first cycle with the new `m`. No state is cleared; `o` simply re-evaluates.
- **Edge counter** (macro on): 5-bit `cnt += rise[0]`, wraps 31→0. It is unaffected by hold and mode.
- **Reset**
  - Every flop clears to 0: sync chains, `p`, `t`, `o`, `cnt`.
  - `uo_out = 0x00` and `uio_out = 0x00` while `rst_n = 0`.
  - An input held high across reset release produces one `rise` once it emerges from the synchroniser, because `p` resets to 0.
- **Reset mid-operation**: asynchronous clear of all state, with no partial pulse or toggle retained.

## Timing
- **Latency**: a `ui_in` change sampled at edge k appears on `uo_out` at edge k+`SYNC_STAGES` (k+2 by default).
- **Control latency**: the same for mode and hold, so data and mode changed on the same edge are processed together.
- **PULSE width**: exactly 1 cycle per rising input edge. The input must stay low ≥1 synced cycle to re-arm.
- **Counter**: updates on the same edge as the corresponding PULSE output.
- **After reset release in INVERT**: `uo_out` becomes `~0 = 0xFF` (masked to `WIDTH`) at the first edge.
- **Inputs**: asynchronous inputs are tolerated; no combinational path from any input to any output.

## Configuration
- **Macro `DSRT_EDGE_CNT_EN`**
  - Defined: the 5-bit counter is built, `uio_out[7:3] = cnt`, `uio_oe = 8'hF8`.
  - Undefined: no counter logic, `uio_out = 8'h00`, `uio_oe = 8'h00`.
- Channel behaviour is identical either way.

## Structure
- **Package `tt_dsrt_pkg`**
  - Mode enum `dsrt_mode_e`: `MODE_INVERT=0`, `MODE_PASS=1`, `MODE_TOGGLE=2`, `MODE_PULSE=3`.
  - `UIO_OE_CNT = 8'hF8`.
  - `CNT_W = 5`.
- **Sub-module `tt_dsrt_sync`**: parametrised width and depth, async active-low clear. Instantiated once for data and once for control.
- The remaining logic lives in the top.

## Test plan
- **Reset**: `WIDTH=8`, `SYNC_STAGES=2`, mode 0, `ui_in=0x00`, reset held → `uo_out=0x00`. Release → `uo_out=0xFF` at the first edge.
- **INVERT**: `ui_in` 0x00→0xA5 sampled at edge k → `uo_out=0x5A` from edge k+2, not earlier.
- **PULSE**: mode 3, `ui_in[0]` 0→1 and held → `uo_out[0]=1` for exactly one cycle at k+2, then 0. Other bits stay 0.
- **TOGGLE**: mode 2, four rising edges on `ui_in[3]` spaced 4 cycles apart → `uo_out[3]` follows 1,0,1,0. Switch to PASS with input low → `uo_out=0x00`.
- **Hold**: mode 1 with `uio_in[2]=1`, `ui_in` 0x0F→0xF0 → `uo_out` stays 0x0F. Clear hold → 0xF0 two cycles after hold clears.
- **Counter, macro on**: 33 rising edges on `ui_in[0]` → `uio_out[7:3]=1` (wrap), `uio_oe=0xF8`.
- **Counter, macro off**: `uio_out=0x00`, `uio_oe=0x00` throughout.
- **WIDTH=4**: `ui_in=0xFF` in INVERT → `uo_out=0x00`; PASS → `uo_out=0x0F`.
